// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - shared VGA timing constants and coordinate type
//
// Default 640x480@60 Hz timing (25.175 MHz pixel clock), sync polarity and
// coordinate width. The raster generator, pixel-drawing stage and game logic
// all import this package so they agree on the screen geometry.
package vga_timing_gen_pkg;

  localparam int COORD_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // 0 = sync pulses are active-low, 1 = active-high
  localparam int SYNC_POL_DEF = 0;

  typedef logic [COORD_W-1:0] coord_t;

  // True when v is representable as an unsigned COORD_W-bit value.
  function automatic bit fits_coord(input int v);
    return (v >= 0) && (v < (1 << COORD_W));
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - modulo-N raster axis counter with wrap strobe
//
// Ports:
//   clk    in   clock
//   reset  in   asynchronous active-high reset; count returns to MODULUS-1
//   en     in   advance the count this cycle
//   count  out  W-bit position, 0..MODULUS-1
//   wrap   out  high in the cycle that count advances from MODULUS-1 to 0
module vga_axis_counter #(
  parameter int MODULUS = 800,
  parameter int W       = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  // Resetting to the last position parks the raster in blanking, so the
  // first enabled edge lands on position 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= LAST;
    end else if (en) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign wrap = en && (count == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator for the Pong display
//
// Optional macro VGA_SYNC_DELAY_EN: when defined, de/hsync/vsync are delayed
// by one clk_pxl to line up with a registered pixel-colour stage; sx, sy and
// the strobes are not delayed.
//
// Ports:
//   clk_pxl       in   pixel clock
//   reset         in   asynchronous active-high reset
//   sx            out  horizontal position, 0..H_TOTAL-1
//   sy            out  vertical position, 0..V_TOTAL-1
//   de            out  display enable (visible area)
//   hsync         out  horizontal sync, asserted at level SYNC_POL
//   vsync         out  vertical sync, asserted at level SYNC_POL
//   frame_start   out  one-cycle pulse at sx=0, sy=0
//   vblank_start  out  one-cycle pulse at sx=0, sy=V_ACTIVE (game tick)
//   frame_cnt     out  frame counter, wraps 255->0
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int SYNC_POL = SYNC_POL_DEF
) (
  input  logic               clk_pxl,
  input  logic               reset,
  output logic [COORD_W-1:0] sx,
  output logic [COORD_W-1:0] sy,
  output logic               de,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start,
  output logic               vblank_start,
  output logic [7:0]         frame_cnt
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam coord_t H_ACT_C = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_C = coord_t'(V_ACTIVE);
  localparam coord_t HS_S_C  = coord_t'(HS_START);
  localparam coord_t HS_E_C  = coord_t'(HS_END);
  localparam coord_t VS_S_C  = coord_t'(VS_START);
  localparam coord_t VS_E_C  = coord_t'(VS_END);

  localparam logic SYNC_ON = (SYNC_POL != 0);

  // Every derived constant is at most its axis total, so bounding the
  // totals bounds them all.
  if (!fits_coord(H_TOTAL) || !fits_coord(V_TOTAL) ||
      H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_param_err
    $error("vga_timing_gen: timing parameters do not fit %0d-bit coordinates", COORD_W);
  end

  logic h_wrap;
  logic v_wrap;

  vga_axis_counter #(
    .MODULUS(H_TOTAL),
    .W      (COORD_W)
  ) u_h_axis (
    .clk  (clk_pxl),
    .reset(reset),
    .en   (1'b1),
    .count(sx),
    .wrap (h_wrap)
  );

  // Vertical axis only moves on the horizontal wrap, so sy changes
  // exactly when sx returns to 0 and vsync is line-aligned.
  vga_axis_counter #(
    .MODULUS(V_TOTAL),
    .W      (COORD_W)
  ) u_v_axis (
    .clk  (clk_pxl),
    .reset(reset),
    .en   (h_wrap),
    .count(sy),
    .wrap (v_wrap)
  );

  always_ff @(posedge clk_pxl or posedge reset) begin
    if (reset) begin
      frame_cnt <= 8'd0;
    end else if (v_wrap) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  logic de_raw;
  logic hsync_raw;
  logic vsync_raw;

  assign de_raw    = (sx < H_ACT_C) && (sy < V_ACT_C);
  assign hsync_raw = ((sx >= HS_S_C) && (sx < HS_E_C)) ? SYNC_ON : ~SYNC_ON;
  assign vsync_raw = ((sy >= VS_S_C) && (sy < VS_E_C)) ? SYNC_ON : ~SYNC_ON;

  assign frame_start  = (sx == '0) && (sy == '0);
  assign vblank_start = (sx == '0) && (sy == V_ACT_C);

`ifdef VGA_SYNC_DELAY_EN
  logic de_q;
  logic hsync_q;
  logic vsync_q;

  always_ff @(posedge clk_pxl or posedge reset) begin
    if (reset) begin
      de_q    <= 1'b0;
      hsync_q <= ~SYNC_ON;
      vsync_q <= ~SYNC_ON;
    end else begin
      de_q    <= de_raw;
      hsync_q <= hsync_raw;
      vsync_q <= vsync_raw;
    end
  end

  assign de    = de_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
`else
  assign de    = de_raw;
  assign hsync = hsync_raw;
  assign vsync = vsync_raw;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  // Reduced-geometry instance: 15 x 10 raster, active-high syncs
  localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VA = 6, S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int FR_D = 800 * 525;
  localparam int FR_S = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);

`ifdef VGA_SYNC_DELAY_EN
  localparam int DE_FIRST = 0;
  localparam int HS_FIRST = 657;
`else
  localparam int DE_FIRST = 1;
  localparam int HS_FIRST = 656;
`endif

  logic       clk_pxl = 1'b0;
  logic       reset;
  logic       reset_s;
  logic       cmp_en = 1'b0;

  logic [9:0] sx, sy, sx_s, sy_s;
  logic       de, hsync, vsync, frame_start, vblank_start;
  logic       de_s, hsync_s, vsync_s, frame_start_s, vblank_start_s;
  logic [7:0] frame_cnt, frame_cnt_s;

  always #5 clk_pxl = ~clk_pxl;

  vga_timing_gen dut (
    .clk_pxl     (clk_pxl),
    .reset       (reset),
    .sx          (sx),
    .sy          (sy),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start),
    .vblank_start(vblank_start),
    .frame_cnt   (frame_cnt)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .SYNC_POL(1)
  ) dut_s (
    .clk_pxl     (clk_pxl),
    .reset       (reset_s),
    .sx          (sx_s),
    .sy          (sy_s),
    .de          (de_s),
    .hsync       (hsync_s),
    .vsync       (vsync_s),
    .frame_start (frame_start_s),
    .vblank_start(vblank_start_s),
    .frame_cnt   (frame_cnt_s)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int sx; int sy; int de; int hs; int vs; int fs; int vb;
  } exp_t;

  // Everything on screen is a function of the linear pixel index within
  // the frame.
  function automatic exp_t decode(input int pos, input int ha, input int hf,
                                  input int hsw, input int hb, input int va,
                                  input int vf, input int vsw, input int pol);
    int   ht;
    exp_t e;
    ht   = ha + hf + hsw + hb;
    e.sx = pos % ht;
    e.sy = pos / ht;
    e.de = (e.sx < ha && e.sy < va) ? 1 : 0;
    e.hs = (e.sx >= ha + hf && e.sx < ha + hf + hsw) ? pol : 1 - pol;
    e.vs = (e.sy >= va + vf && e.sy < va + vf + vsw) ? pol : 1 - pol;
    e.fs = (pos == 0) ? 1 : 0;
    e.vb = (e.sx == 0 && e.sy == va) ? 1 : 0;
    return e;
  endfunction

  // Model state: linear pixel index, previous index (for delayed outputs),
  // frame count.
  int pos_d, prv_d, fc_d;
  int pos_s, prv_s, fc_s;

  always @(posedge clk_pxl or posedge reset) begin
    if (reset) begin
      pos_d <= FR_D - 1;
      prv_d <= FR_D - 1;
      fc_d  <= 0;
    end else begin
      prv_d <= pos_d;
      fc_d  <= (pos_d == FR_D - 1) ? (fc_d + 1) % 256 : fc_d;
      pos_d <= (pos_d + 1) % FR_D;
    end
  end

  always @(posedge clk_pxl or posedge reset_s) begin
    if (reset_s) begin
      pos_s <= FR_S - 1;
      prv_s <= FR_S - 1;
      fc_s  <= 0;
    end else begin
      prv_s <= pos_s;
      fc_s  <= (pos_s == FR_S - 1) ? (fc_s + 1) % 256 : fc_s;
      pos_s <= (pos_s + 1) % FR_S;
    end
  end

  always @(negedge clk_pxl) begin
    exp_t e, ed, f, fd;
    if (cmp_en) begin
      e = decode(pos_d, 640, 16, 96, 48, 480, 10, 2, 0);
      f = decode(pos_s, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, 1);
`ifdef VGA_SYNC_DELAY_EN
      ed = decode(prv_d, 640, 16, 96, 48, 480, 10, 2, 0);
      fd = decode(prv_s, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, 1);
`else
      ed = e;
      fd = f;
`endif
      chk("m_sx", sx, e.sx);
      chk("m_sy", sy, e.sy);
      chk("m_de", de, ed.de);
      chk("m_hsync", hsync, ed.hs);
      chk("m_vsync", vsync, ed.vs);
      chk("m_frame_start", frame_start, e.fs);
      chk("m_vblank_start", vblank_start, e.vb);
      chk("m_frame_cnt", frame_cnt, fc_d);
      chk("ms_sx", sx_s, f.sx);
      chk("ms_sy", sy_s, f.sy);
      chk("ms_de", de_s, fd.de);
      chk("ms_hsync", hsync_s, fd.hs);
      chk("ms_vsync", vsync_s, fd.vs);
      chk("ms_frame_start", frame_start_s, f.fs);
      chk("ms_vblank_start", vblank_start_s, f.vb);
      chk("ms_frame_cnt", frame_cnt_s, fc_s);
    end
  end

  initial begin
    int de_n, hl_n, hl_first, found;
    int frames, wraps, vs_n, vb_n, last_c, last_fc;

    reset   = 1'b1;
    reset_s = 1'b1;
    @(posedge clk_pxl);
    cmp_en = 1'b1;
    repeat (5) @(negedge clk_pxl);

    chk("rst_sx", sx, 799);
    chk("rst_sy", sy, 524);
    chk("rst_de", de, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_vblank_start", vblank_start, 0);
    chk("rst_frame_cnt", frame_cnt, 0);

    reset   = 1'b0;
    reset_s = 1'b0;
    @(negedge clk_pxl);
    chk("first_sx", sx, 0);
    chk("first_sy", sy, 0);
    chk("first_frame_start", frame_start, 1);
    chk("first_frame_cnt", frame_cnt, 1);
    chk("first_de", de, DE_FIRST);

    // One full line starting at sx=0 of line 0
    de_n = 0; hl_n = 0; hl_first = -1;
    for (int i = 0; i < 800; i++) begin
      if (de) de_n++;
      if (!hsync) begin
        if (hl_first < 0) hl_first = int'(sx);
        hl_n++;
      end
      if (i == 799) chk("line_end_sx", sx, 799);
      @(negedge clk_pxl);
    end
    chk("line_de_count", de_n, 640);
    chk("line_hsync_low", hl_n, 96);
    chk("line_hsync_first", hl_first, HS_FIRST);
    chk("line_wrap_sx", sx, 0);
    chk("line_wrap_sy", sy, 1);

    // Asynchronous reset in the middle of a line
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      if (sx == 10'd300) found = 1;
      else @(negedge clk_pxl);
    end
    chk("wait_sx300", found, 1);
    if (found == 1) begin
      #2 reset = 1'b1;
      #1;
      chk("snap_sx", sx, 799);
      chk("snap_sy", sy, 524);
      chk("snap_de", de, 0);
      chk("snap_frame_cnt", frame_cnt, 0);
      @(negedge clk_pxl);
      reset = 1'b0;
      @(negedge clk_pxl);
      chk("restart_sx", sx, 0);
      chk("restart_sy", sy, 0);
      chk("restart_frame_start", frame_start, 1);
      chk("restart_frame_cnt", frame_cnt, 1);
    end

    // Frame-level behaviour and frame_cnt wrap on the reduced raster
    frames = 0; wraps = 0; vs_n = 0; vb_n = 0; last_c = 0; last_fc = 0;
    for (int c = 0; c < 45000 && frames < 258; c++) begin
      if (frame_start_s) begin
        if (frames > 0) begin
          chk("frm_period", c - last_c, 150);
          chk("frm_vsync_cycles", vs_n, 30);
          chk("frm_vblank_pulses", vb_n, 1);
          chk("frm_cnt_step", frame_cnt_s, (last_fc + 1) % 256);
          if (frame_cnt_s == 8'd0) wraps++;
        end
        last_c  = c;
        last_fc = int'(frame_cnt_s);
        vs_n    = 0;
        vb_n    = 0;
        frames++;
      end
      if (vsync_s) vs_n++;
      if (vblank_start_s) vb_n++;
      @(negedge clk_pxl);
    end
    chk("frames_seen", frames, 258);
    chk("frame_cnt_wraps", wraps, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
